// File: rtl/pipereg_elastic.sv
// Elastic valid/ready pipeline register between core stages: circular buffer
// with synchronous flush and saturating stall/bubble performance counters.
module pipereg_elastic #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         bubble_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              push, pop, wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready comes only from registered occupancy, so a full buffer refuses a
  // push even while it pops; this keeps out_ready_i off the in_ready_o path.
  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign wr_en       = push & ~flush_i & reset_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Counters observe the handshake even in a flush cycle.
  always_comb begin
    stall_d  = (out_valid_o & ~out_ready_i) ? sat_inc(stall_q)  : stall_q;
    bubble_d = (~out_valid_o & out_ready_i) ? sat_inc(bubble_q) : bubble_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data_i;
  end

  assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_pipereg_elastic.sv
// Directed bench for pipereg_elastic: DEPTH=2/CNT_W=32 and DEPTH=4/CNT_W=4
// instances driven by shared stimulus, checked against hand-computed values.
module tb_pipereg_elastic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [95:0] in_data;

  logic        rdy2, vld2, rdy4, vld4;
  logic [95:0] data2, data4;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;
  logic [31:0] stall2, bubble2;
  logic [3:0]  stall4, bubble4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipereg_elastic #(.DATA_W(96), .DEPTH(2), .CNT_W(32)) u_d2 (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy2), .in_data_i(in_data),
    .out_valid_o(vld2), .out_ready_i(out_ready), .out_data_o(data2),
    .count_o(cnt2), .stall_cnt_o(stall2), .bubble_cnt_o(bubble2)
  );

  pipereg_elastic #(.DATA_W(96), .DEPTH(4), .CNT_W(4)) u_d4 (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy4), .in_data_i(in_data),
    .out_valid_o(vld4), .out_ready_i(out_ready), .out_data_o(data4),
    .count_o(cnt4), .stall_cnt_o(stall4), .bubble_cnt_o(bubble4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held 3 cycles with a payload offered
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'h77;
    repeat (3) step();
    chk("rst_count",  128'(cnt4),    128'(0));
    chk("rst_valid",  128'(vld4),    128'(0));
    chk("rst_data",   128'(data4),   128'(0));
    chk("rst_ready",  128'(rdy4),    128'(1));
    chk("rst_stall",  128'(stall4),  128'(0));
    chk("rst_bubble", 128'(bubble4), 128'(0));
    chk("rst_valid2", 128'(vld2),    128'(0));
    chk("rst_bub2",   128'(bubble2), 128'(0));

    // Streaming through DEPTH=2
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 96'(i);
      step();
      chk("stream_valid", 128'(vld2),  128'(1));
      chk("stream_data",  128'(data2), 128'(i));
      chk("stream_ready", 128'(rdy2),  128'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 128'(vld2),    128'(0));
    chk("stream_bubble",  128'(bubble2), 128'(1));
    chk("stream_stall",   128'(stall2),  128'(0));

    // Fill DEPTH=4 with the consumer stalled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 96'(32'hA + i);
      step();
      chk("fill_count", 128'(cnt4), 128'(i + 1));
    end
    chk("full_ready", 128'(rdy4),   128'(0));
    chk("fill_stall", 128'(stall4), 128'(3));
    in_data = 96'hE;
    repeat (4) step();
    chk("full_count_hold", 128'(cnt4),   128'(4));
    chk("full_head_hold",  128'(data4),  128'(32'hA));
    chk("hold_stall",      128'(stall4), 128'(7));

    // Full and popping in the same cycle: pop only
    out_ready = 1'b1;
    step();
    chk("fullpop_count", 128'(cnt4),   128'(3));
    chk("fullpop_data",  128'(data4),  128'(32'hB));
    chk("fullpop_stall", 128'(stall4), 128'(7));

    // Continuous stream across the pointer wrap
    for (int i = 0; i < 3; i++) begin
      in_data = 96'(32'hE + i);
      step();
      chk("wrap_data",  128'(data4), 128'(32'hC + i));
      chk("wrap_count", 128'(cnt4),  128'(3));
    end
    in_valid = 1'b0;
    step();
    chk("wrap_tail_f", 128'(data4), 128'(32'hF));
    step();
    chk("wrap_tail_g", 128'(data4), 128'(32'h10));
    step();
    chk("wrap_empty",  128'(vld4),  128'(0));

    // Flush with a push offered in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 96'(32'h11 * (i + 1));
      step();
    end
    chk("pre_flush_count", 128'(cnt4),   128'(3));
    chk("pre_flush_stall", 128'(stall4), 128'(2));
    flush = 1'b1; in_data = 96'h55;
    step();
    chk("flush_count",  128'(cnt4),    128'(0));
    chk("flush_valid",  128'(vld4),    128'(0));
    chk("flush_ready",  128'(rdy4),    128'(1));
    chk("flush_data",   128'(data4),   128'(0));
    chk("flush_stall",  128'(stall4),  128'(3));
    chk("flush_bubble", 128'(bubble4), 128'(0));
    flush = 1'b0; in_data = 96'h66;
    step();
    chk("post_flush_data",  128'(data4), 128'(32'h66));
    chk("post_flush_count", 128'(cnt4),  128'(1));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("post_flush_empty", 128'(vld4), 128'(0));
    step();
    chk("no_ghost_valid", 128'(vld4),    128'(0));
    chk("post_bubble",    128'(bubble4), 128'(1));

    // Bubble counter saturation at CNT_W=4
    do_reset();
    out_ready = 1'b1;
    repeat (15) step();
    chk("sat_reach", 128'(bubble4), 128'(15));
    repeat (5) step();
    chk("sat_hold",  128'(bubble4), 128'(15));
    chk("wide_bub",  128'(bubble2), 128'(20));
    chk("sat_stall", 128'(stall4),  128'(0));

    // Reset mid-operation clears the counters
    do_reset();
    chk("rerst_bubble", 128'(bubble4), 128'(0));
    chk("rerst_count",  128'(cnt4),    128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
